cim_host_ctrl: RTL
==================

CIM_HOST_CTRL -- requirements
Module: cim_host_ctrl

Interface
REQ-001 Parameters SHALL be ROWS=8 (weight rows, one-hot WA), DW=24 (weight word), XW=192 (activation vector), NW=51 (result), TIMEOUT=1024 (cycles waiting for st).
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 w_valid/w_ready/w_data  in/out/in  1/1/DW  weight stream, one row per beat, rows written in order 0..ROWS-1.
REQ-005 x_valid/x_ready/x_data  in/out/in  1/1/XW  compute-job stream, one activation vector per beat.
REQ-006 cfg_cima/cfg_inwidth/cfg_wwidth  in  1 each  mode bits, sampled with each accepted x beat.
REQ-007 r_valid/r_ready/r_data  out/in/out  1/1/NW  result stream.
REQ-008 WA/D  out  ROWS/DW  macro write port: one-hot row address, write data.
REQ-009 start/xin0/cima/inwidth/wwidth  out  1/XW/1/1/1  macro compute launch.
REQ-010 nout/st  in  NW/1  macro result and done strobe.
REQ-011 loaded/busy/err  out  1/1/1  all ROWS rows written / FSM not IDLE / sticky timeout flag.

Function
REQ-012 FSM states SHALL be IDLE, WR, GAP, LAUNCH, WAIT, HOLD.
REQ-013 IDLE: w_ready=1; x_ready=loaded & ~r_valid & ~w_valid (weights have priority when both valid).
REQ-014 Weight accept (w_valid&w_ready) SHALL go to WR: next cycle WA=1<<row, D=w_data, for exactly one cycle.
REQ-015 GAP SHALL drive WA=0 for one cycle (D held), then row increments and FSM returns to IDLE; weight-to-weight throughput SHALL be one row per 3 cycles.
REQ-016 Row counter SHALL wrap ROWS-1 -> 0; loaded SHALL clear on accepting row 0 and set at GAP exit of row ROWS-1.
REQ-017 WA SHALL be all-zero in every state other than WR; never more than one bit set.
REQ-018 x accept SHALL register x_data into xin0 and cfg bits into cima/inwidth/wwidth; these SHALL stay stable until return to IDLE.
REQ-019 LAUNCH SHALL assert start for exactly 2 cycles, starting the cycle after x accept, then enter WAIT.
REQ-020 WAIT SHALL detect st rising edge (st=1 now, 0 previous cycle); on it capture nout into r_data, set r_valid, enter HOLD.
REQ-021 st already high on WAIT entry SHALL NOT count; a fresh 0->1 transition is required.
REQ-022 WAIT timeout counter reaching TIMEOUT SHALL set err (sticky until rst), discard job, return to IDLE with no result.
REQ-023 HOLD: r_data stable while r_valid&~r_ready; on r_ready, r_valid clears same edge and FSM returns to IDLE.
REQ-024 Accept into IDLE and r_ready in HOLD SHALL be mutually non-blocking: earliest next x accept is the cycle after r_valid drops.
REQ-025 Weight reload mid-sequence (loaded=0, row>0) SHALL block x_ready until all ROWS rows rewritten.

Reset
REQ-026 On rst: FSM=IDLE, row=0, WA=0, D=0, start=0, xin0=0, cima=inwidth=wwidth=0, r_valid=0, r_data=0, loaded=0, err=0, timeout counter=0, st history=0.
REQ-027 rst asserted in any state (including WR or WAIT) SHALL abort immediately; no partial write or result survives.

Structure
REQ-028 Shared package cim_pkg SHALL hold ROWS, DW, XW, NW, TIMEOUT defaults and the FSM state enum.
REQ-029 One sub-module cim_res_buf (single-entry valid/ready result register) SHALL implement HOLD storage.

Verification
REQ-030 Load rows 9..16 back-to-back -> WA sequence 01,00,02,00,...,80,00 with D=9..16; loaded=1 after 24 cycles.
REQ-031 x_data=192'haaa...aaa before loaded -> x_ready=0, no start; after load -> start high 2 cycles, xin0 matches.
REQ-032 Model st 0->1 with nout=51'h123 after 40 cycles, r_ready=0 for 5 cycles -> r_valid held, r_data=51'h123, busy=1 until r_ready.
REQ-033 st held high across LAUNCH, never toggled -> no result; after TIMEOUT cycles err=1, FSM IDLE.
REQ-034 rst pulsed during WR of row 3 -> WA=0 same cycle (async), loaded=0, next load starts at row 0.
REQ-035 w_valid and x_valid both high in IDLE with loaded=1 -> weight accepted first, loaded clears, x stalled until 8 rows done.

Source files
------------

// File: rtl/cim_pkg.sv
// Shared defaults and FSM encoding for the CIM macro host controller.
package cim_pkg;

  localparam int ROWS    = 8;
  localparam int DW      = 24;
  localparam int XW      = 192;
  localparam int NW      = 51;
  localparam int TIMEOUT = 1024;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    GAP,
    LAUNCH,
    WAIT,
    HOLD
  } state_e;

endpackage

// File: rtl/cim_res_buf.sv
// Single-entry valid/ready result register: loads on capture, drops valid on ready.
module cim_res_buf #(
  parameter int W = cim_pkg::NW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/cim_host_ctrl.sv
// Host-side sequencer for a CIM macro: streams weight rows into the array,
// launches compute jobs, waits for the done strobe and returns the result.
module cim_host_ctrl #(
  parameter int ROWS    = cim_pkg::ROWS,
  parameter int DW      = cim_pkg::DW,
  parameter int XW      = cim_pkg::XW,
  parameter int NW      = cim_pkg::NW,
  parameter int TIMEOUT = cim_pkg::TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            w_valid,
  output logic            w_ready,
  input  logic [DW-1:0]   w_data,
  input  logic            x_valid,
  output logic            x_ready,
  input  logic [XW-1:0]   x_data,
  input  logic            cfg_cima,
  input  logic            cfg_inwidth,
  input  logic            cfg_wwidth,
  output logic            r_valid,
  input  logic            r_ready,
  output logic [NW-1:0]   r_data,
  output logic [ROWS-1:0] WA,
  output logic [DW-1:0]   D,
  output logic            start,
  output logic [XW-1:0]   xin0,
  output logic            cima,
  output logic            inwidth,
  output logic            wwidth,
  input  logic [NW-1:0]   nout,
  input  logic            st,
  output logic            loaded,
  output logic            busy,
  output logic            err
);

  import cim_pkg::*;

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  state_e          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [DW-1:0]   d_q, d_d;
  logic [XW-1:0]   xin0_q, xin0_d;
  logic [2:0]      cfg_q, cfg_d;
  logic            loaded_q, loaded_d;
  logic            err_q, err_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            lcnt_q, lcnt_d;
  logic            st_prev_q;
  logic            res_load;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; that is what keeps this block free of inferred latches.
    state_d  = state_q;
    row_d    = row_q;
    d_d      = d_q;
    xin0_d   = xin0_q;
    cfg_d    = cfg_q;
    loaded_d = loaded_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    lcnt_d   = lcnt_q;
    res_load = 1'b0;
    w_ready  = 1'b0;
    x_ready  = 1'b0;

    unique case (state_q)
      IDLE: begin
        w_ready = 1'b1;
        x_ready = loaded_q & ~r_valid & ~w_valid;
        if (w_valid) begin
          state_d = WR;
          d_d     = w_data;
          if (row_q == '0) loaded_d = 1'b0;
        end else if (x_valid && x_ready) begin
          state_d = LAUNCH;
          xin0_d  = x_data;
          cfg_d   = {cfg_cima, cfg_inwidth, cfg_wwidth};
          lcnt_d  = 1'b0;
        end
      end
      WR: state_d = GAP;
      GAP: begin
        state_d = IDLE;
        if (row_q == RW'(ROWS - 1)) begin
          row_d    = '0;
          loaded_d = 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      LAUNCH: begin
        if (lcnt_q) begin
          state_d = WAIT;
          tmo_d   = '0;
        end else begin
          lcnt_d = 1'b1;
        end
      end
      WAIT: begin
        // Only a fresh 0->1 on st counts; a level already high at entry is stale.
        if (st && !st_prev_q) begin
          res_load = 1'b1;
          state_d  = HOLD;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      HOLD: begin
        if (r_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      row_q     <= '0;
      d_q       <= '0;
      xin0_q    <= '0;
      cfg_q     <= '0;
      loaded_q  <= 1'b0;
      err_q     <= 1'b0;
      tmo_q     <= '0;
      lcnt_q    <= 1'b0;
      st_prev_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      row_q     <= row_d;
      d_q       <= d_d;
      xin0_q    <= xin0_d;
      cfg_q     <= cfg_d;
      loaded_q  <= loaded_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
      lcnt_q    <= lcnt_d;
      st_prev_q <= st;
    end
  end

  cim_res_buf #(
    .W(NW)
  ) u_res_buf (
    .clk    (clk),
    .rst    (rst),
    .load_i (res_load),
    .data_i (nout),
    .ready_i(r_ready),
    .valid_o(r_valid),
    .data_o (r_data)
  );

  // WA decodes straight from state so reset clears it without waiting for a clock.
  assign WA      = (state_q == WR) ? (ROWS'(1) << row_q) : '0;
  assign D       = d_q;
  assign start   = (state_q == LAUNCH);
  assign xin0    = xin0_q;
  assign cima    = cfg_q[2];
  assign inwidth = cfg_q[1];
  assign wwidth  = cfg_q[0];
  assign loaded  = loaded_q;
  assign busy    = (state_q != IDLE);
  assign err     = err_q;

endmodule
